// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver with a show-ahead byte FIFO.
// Bit timing comes from a phase accumulator on the system clock.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rx,
  output logic [7:0]                     m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                           rx_busy,
  output logic                           frame_err,
  output logic                           overrun
);

  localparam int INC   = BAUD * OVERSAMPLE;
  localparam int ACC_W = $clog2(CLK_HZ + INC);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic              tick;
  logic [1:0]        sync_q;
  logic              rs;
  logic [3:0]        sc_q;
  logic [3:0]        nb_q;
  logic [7:0]        sh_q;
  logic              m7_q, m8_q;
  logic              armed_q;
  logic              maj;
  logic              at9, at15;
  logic              push_req, ferr_d;
  logic              frame_err_q, overrun_q;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q, rptr_nx;
  logic [LVL_W-1:0]  level_q;
  logic [7:0]        m_data_q;
  logic              m_valid_q;
  logic              pop, accept, push;

  always_comb begin
    acc_sum = acc_q + ACC_W'(INC);
    tick    = (acc_sum >= ACC_W'(CLK_HZ));
    acc_d   = tick ? acc_sum - ACC_W'(CLK_HZ) : acc_sum;
  end

  assign rs   = sync_q[1];
  assign maj  = (m7_q & m8_q) | (m7_q & rs) | (m8_q & rs);
  assign at9  = tick & (sc_q == 4'd9);
  assign at15 = tick & (sc_q == 4'd15);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (tick & armed_q & ~rs) state_d = START;
      START: if (at9) state_d = maj ? IDLE : DATA;
      DATA:  if (at15 && nb_q == 4'd8) state_d = STOP;
      STOP:  if (at9) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_busy  = (state_q != IDLE);
    push_req = (state_q == STOP) & at9 & maj;
    ferr_d   = (state_q == STOP) & at9 & ~maj;
  end

  // sc keeps counting from the start-bit centre so data bits stay centred
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      sync_q      <= 2'b11;
      sc_q        <= '0;
      nb_q        <= '0;
      sh_q        <= '0;
      m7_q        <= 1'b1;
      m8_q        <= 1'b1;
      armed_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      sync_q <= {sync_q[0], rx};
      if (tick) begin
        sc_q <= (state_q == IDLE) ? 4'd0 : sc_q + 4'd1;
        if (sc_q == 4'd7) m7_q <= rs;
        if (sc_q == 4'd8) m8_q <= rs;
        if (state_q == IDLE && rs) armed_q <= 1'b1;
        if (state_q == START && sc_q == 4'd9) nb_q <= '0;
        if (state_q == DATA && sc_q == 4'd9) begin
          sh_q <= {maj, sh_q[7:1]};
          nb_q <= nb_q + 4'd1;
        end
      end
      if (ferr_d) armed_q <= 1'b0;
      frame_err_q <= ferr_d;
      overrun_q   <= push_req & ~accept;
    end
  end

  assign pop     = m_valid_q & m_ready;
  assign accept  = (level_q < LVL_W'(FIFO_DEPTH)) | pop;
  assign push    = push_req & accept;
  assign rptr_nx = rptr_q + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= sh_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_nx;
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
      if (pop && level_q == LVL_W'(1)) begin
        if (push) m_data_q  <= sh_q;
        else      m_valid_q <= 1'b0;
      end else if (pop) begin
        m_data_q <= mem_q[rptr_nx];
      end else if (push && level_q == '0) begin
        m_data_q  <= sh_q;
        m_valid_q <= 1'b1;
      end
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign fifo_level = level_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames, FIFO fill/overrun,
// framing error with break, glitch, rate skew and mid-frame reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [3:0] fifo_level;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  int fe_cnt = 0;
  int ov_cnt = 0;
  int vcyc = 0;
  logic [7:0] got [$];

  uart_rx_fifo dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .fifo_level(fifo_level),
    .rx_busy(rx_busy),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
    if (m_valid)   vcyc <= vcyc + 1;
    if (m_valid && m_ready) got.push_back(m_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_bit(input logic v, input int n);
    rx = v;
    step(n);
  endtask

  task automatic send(input logic [7:0] b, input int cpb,
                      input logic stopv);
    rx_bit(1'b0, cpb);
    for (int i = 0; i < 8; i++) rx_bit(b[i], cpb);
    rx_bit(stopv, cpb);
    rx = 1'b1;
  endtask

  int fe0, ov0, v0, g0;
  int k;
  logic [7:0] t5 [6];

  initial begin
    t5[0] = 8'h00; t5[1] = 8'hFF; t5[2] = 8'h5A;
    t5[3] = 8'h00; t5[4] = 8'hFF; t5[5] = 8'h5A;

    step(5);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    step(434);

    // T1
    m_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcyc; g0 = got.size();
    send(8'hA5, 217, 1'b1);
    step(217);
    chk("t1_count", got.size() - g0, 1);
    chk("t1_data", got[g0], 8'hA5);
    chk("t1_valid_cycles", vcyc - v0, 1);
    chk("t1_fe", fe_cnt - fe0, 0);
    chk("t1_ov", ov_cnt - ov0, 0);
    chk("t1_level", fifo_level, 0);

    // T2
    m_ready = 1'b0;
    ov0 = ov_cnt; fe0 = fe_cnt; g0 = got.size();
    for (int i = 1; i <= 9; i++) begin
      send(8'(i), 217, 1'b1);
      step(217);
    end
    chk("t2_level_full", fifo_level, 8);
    chk("t2_overrun_once", ov_cnt - ov0, 1);
    chk("t2_fe", fe_cnt - fe0, 0);
    chk("t2_head_valid", m_valid, 1);
    chk("t2_head_data", m_data, 8'h01);
    m_ready = 1'b1;
    step(20);
    chk("t2_pop_count", got.size() - g0, 8);
    for (int i = 0; i < 8; i++)
      chk("t2_pop_order", got[g0 + i], 32'(i + 1));
    chk("t2_level_empty", fifo_level, 0);
    chk("t2_valid_low", m_valid, 0);

    // T3
    fe0 = fe_cnt; g0 = got.size(); ov0 = ov_cnt;
    send(8'h3C, 217, 1'b0);
    rx = 1'b0;
    step(3 * 217);
    rx = 1'b1;
    chk("t3_fe_cycles", fe_cnt - fe0, 1);
    chk("t3_level", fifo_level, 0);
    chk("t3_no_byte", got.size() - g0, 0);
    step(434);
    send(8'h55, 217, 1'b1);
    step(217);
    chk("t3_count", got.size() - g0, 1);
    chk("t3_data", got[g0], 8'h55);
    chk("t3_fe_after", fe_cnt - fe0, 1);
    chk("t3_ov", ov_cnt - ov0, 0);

    // T4
    fe0 = fe_cnt; ov0 = ov_cnt; g0 = got.size();
    rx_bit(1'b0, 6);
    rx = 1'b1;
    k = 0;
    while (rx_busy !== 1'b0 || k < 4) begin
      step(1);
      k++;
      if (k > 217) break;
    end
    chk("t4_busy_timeout", (k <= 217), 1);
    chk("t4_busy", rx_busy, 0);
    step(217);
    chk("t4_no_byte", got.size() - g0, 0);
    chk("t4_fe", fe_cnt - fe0, 0);
    chk("t4_ov", ov_cnt - ov0, 0);

    // T5
    g0 = got.size(); fe0 = fe_cnt;
    for (int i = 0; i < 3; i++) begin
      send(t5[i], 211, 1'b1);
      step(434);
    end
    for (int i = 3; i < 6; i++) begin
      send(t5[i], 224, 1'b1);
      step(434);
    end
    chk("t5_count", got.size() - g0, 6);
    for (int i = 0; i < 6; i++)
      chk("t5_data", got[g0 + i], t5[i]);
    chk("t5_fe", fe_cnt - fe0, 0);

    // T6
    m_ready = 1'b0;
    send(8'h11, 217, 1'b1);
    step(217);
    send(8'h22, 217, 1'b1);
    step(217);
    chk("t6_level2", fifo_level, 2);
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx_bit(1'b0, 217);
    rx_bit(1'b1, 217);
    rx_bit(1'b1, 217);
    rx_bit(1'b0, 100);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_data", m_data, 0);
    chk("t6_rst_busy", rx_busy, 0);
    step(116);
    rx_bit(1'b0, 3 * 217);
    rx_bit(1'b1, 3 * 217);
    step(217);
    chk("t6_ignored_level", fifo_level, 0);
    chk("t6_ignored_valid", m_valid, 0);
    chk("t6_fe", fe_cnt - fe0, 0);
    chk("t6_ov", ov_cnt - ov0, 0);
    m_ready = 1'b1;
    g0 = got.size();
    send(8'h7E, 217, 1'b1);
    step(217);
    chk("t6_count", got.size() - g0, 1);
    chk("t6_data", got[g0], 8'h7E);
    chk("t6_level_end", fifo_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
